// File: rtl/cc_frame_feeder.sv
// Frame feeder for the X/Y cross-correlation FFT pair: captures N/2 sample pairs,
// configures both FFT cores, then streams one zero-padded, beat-locked N-point frame per channel.
//   state    | meaning
//   S_FILL   | accept input pairs into the capture buffers
//   S_CFG    | present CFG_WORD to both FFT config ports
//   S_STREAM | stream beats 0..N-1 to both FFT data ports
module cc_frame_feeder #(
  parameter int          N        = 256,
  parameter int          IN_W     = 10,
  parameter logic [23:0] CFG_WORD = 24'h00AAAD
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_x,
  input  logic [IN_W-1:0] in_y,
  output logic [23:0]     x_cfg_tdata,
  output logic [23:0]     y_cfg_tdata,
  output logic            x_cfg_tvalid,
  input  logic            x_cfg_tready,
  output logic            y_cfg_tvalid,
  input  logic            y_cfg_tready,
  output logic [31:0]     x_tdata,
  output logic            x_tvalid,
  output logic            x_tlast,
  input  logic            x_tready,
  output logic [31:0]     y_tdata,
  output logic            y_tvalid,
  output logic            y_tlast,
  input  logic            y_tready,
  output logic            frame_start,
  output logic            busy
);
  localparam int HALF = N / 2;
  localparam int AW   = $clog2(HALF);
  localparam int BW   = $clog2(N);

  typedef enum logic [1:0] {S_FILL, S_CFG, S_STREAM} state_t;
  state_t state, state_nxt;

  logic [IN_W-1:0] x_buf [HALF];
  logic [IN_W-1:0] y_buf [HALF];
  logic [IN_W-1:0] rd_x, rd_y;
  logic [AW-1:0]   wr_ptr, rd_idx;
  logic [BW-1:0]   beat, beat_inc, beat_nxt, load_beat;
  logic            x_cfg_done, y_cfg_done, x_done, y_done;
  logic            fill_acc, fill_last, cfg_go, adv, last_beat, load;

  function automatic logic [31:0] pack_re(input logic [IN_W-1:0] s);
    pack_re = {16'b0, {(16-IN_W){s[IN_W-1]}}, s};
  endfunction

  assign x_cfg_tdata = CFG_WORD;
  assign y_cfg_tdata = CFG_WORD;
  assign busy        = (state != S_FILL);

  assign fill_acc  = in_valid & in_ready;
  assign fill_last = fill_acc & (wr_ptr == AW'(HALF - 1));
  assign cfg_go    = (state == S_CFG)
                   & (x_cfg_done | (x_cfg_tvalid & x_cfg_tready))
                   & (y_cfg_done | (y_cfg_tvalid & y_cfg_tready));
  assign adv       = (state == S_STREAM)
                   & (x_done | (x_tvalid & x_tready))
                   & (y_done | (y_tvalid & y_tready));
  assign last_beat = (beat == BW'(N - 1));
  assign beat_inc  = beat + BW'(1);
  assign beat_nxt  = adv ? beat_inc : beat;
  assign load      = cfg_go | (adv & ~last_beat);
  assign load_beat = cfg_go ? '0 : beat_inc;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:   if (fill_last)         state_nxt = S_CFG;
      S_CFG:    if (cfg_go)            state_nxt = S_STREAM;
      S_STREAM: if (adv && last_beat)  state_nxt = S_FILL;
      default:                         state_nxt = S_FILL;
    endcase
  end

  // Read register always holds the sample for the next beat to be loaded.
  always_comb begin
    rd_idx = '0;
    if (cfg_go)                 rd_idx = AW'(1);
    else if (state == S_STREAM) rd_idx = beat_nxt[AW-1:0] + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      x_buf[wr_ptr] <= in_x;
      y_buf[wr_ptr] <= in_y;
    end
    rd_x <= x_buf[rd_idx];
    rd_y <= y_buf[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      in_ready     <= 1'b0;
      wr_ptr       <= '0;
      x_cfg_tvalid <= 1'b0;
      y_cfg_tvalid <= 1'b0;
      x_cfg_done   <= 1'b0;
      y_cfg_done   <= 1'b0;
      beat         <= '0;
      x_tvalid     <= 1'b0;
      y_tvalid     <= 1'b0;
      x_done       <= 1'b0;
      y_done       <= 1'b0;
      x_tlast      <= 1'b0;
      y_tlast      <= 1'b0;
      x_tdata      <= '0;
      y_tdata      <= '0;
      frame_start  <= 1'b0;
    end else begin
      in_ready    <= (state_nxt == S_FILL);
      frame_start <= adv & (beat == '0);
      if (fill_acc) wr_ptr <= wr_ptr + AW'(1);

      if (fill_last) begin
        x_cfg_tvalid <= 1'b1;
        y_cfg_tvalid <= 1'b1;
        x_cfg_done   <= 1'b0;
        y_cfg_done   <= 1'b0;
      end else if (cfg_go) begin
        x_cfg_tvalid <= 1'b0;
        y_cfg_tvalid <= 1'b0;
        x_cfg_done   <= 1'b0;
        y_cfg_done   <= 1'b0;
      end else begin
        if (x_cfg_tvalid && x_cfg_tready) begin
          x_cfg_tvalid <= 1'b0;
          x_cfg_done   <= 1'b1;
        end
        if (y_cfg_tvalid && y_cfg_tready) begin
          y_cfg_tvalid <= 1'b0;
          y_cfg_done   <= 1'b1;
        end
      end

      // X carries its samples in the upper half of the frame, Y in the lower half.
      if (load) begin
        beat     <= load_beat;
        x_tvalid <= 1'b1;
        y_tvalid <= 1'b1;
        x_done   <= 1'b0;
        y_done   <= 1'b0;
        x_tlast  <= (load_beat == BW'(N - 1));
        y_tlast  <= (load_beat == BW'(N - 1));
        x_tdata  <= load_beat[BW-1] ? pack_re(rd_x) : '0;
        y_tdata  <= load_beat[BW-1] ? '0 : pack_re(rd_y);
      end else if (adv) begin
        beat     <= '0;
        x_tvalid <= 1'b0;
        y_tvalid <= 1'b0;
        x_done   <= 1'b0;
        y_done   <= 1'b0;
        x_tlast  <= 1'b0;
        y_tlast  <= 1'b0;
        x_tdata  <= '0;
        y_tdata  <= '0;
      end else begin
        if (x_tvalid && x_tready) begin
          x_tvalid <= 1'b0;
          x_done   <= 1'b1;
        end
        if (y_tvalid && y_tready) begin
          y_tvalid <= 1'b0;
          y_done   <= 1'b1;
        end
      end
    end
  end
endmodule
